size_convert_stream: RTL and testbench
======================================

# size_convert_stream

Parametrised word-to-byte serializer with valid/ready handshakes on both sides. It accepts one IN_BYTES-wide word, or a partial word, and emits it as a stream of bytes in a configurable byte order, flagging the last byte of each word. It replaces the fixed 8/16/32-bit converter in the PHY transmit path, between the per-lane data source and the 8-bit byte-striping logic. It adds backpressure, partial words and arbitrary widths, and sustains one byte per cycle with no bubble between words.

## Interface
- IN_BYTES, 4, input word width in bytes; legal range 1..8.
- MSB_FIRST, 0, byte order: 0 sends DATA_IN[7:0] first, 1 sends the top byte first.
- CW, $clog2(IN_BYTES)+1 (derived, not overridden), width of IN_NBYTES.

Ports:
- PCLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  DATA_IN/IN_NBYTES valid.
- IN_READY  out  1  block can accept a word this cycle.
- DATA_IN  in  8*IN_BYTES  input word.
- IN_NBYTES  in  CW  number of valid bytes, 1..IN_BYTES; 0 or >IN_BYTES treated as IN_BYTES.
- OUT_VALID  out  1  DATA_OUT valid.
- OUT_READY  in  1  downstream accepts byte.
- DATA_OUT  out  8  output byte.
- OUT_LAST  out  1  DATA_OUT is the final byte of its word.
- IDLE_BUFFER  out  1  high when no word is held (state IDLE).

## Operation
- Storage: word register rBuffer, byte-count register rCount (bytes remaining), byte index rIdx.
- States: IDLE (nothing held) and SEND (word held, byte rIdx presented).
- Input transfer: IN_VALID && IN_READY at a rising edge. Output transfer: OUT_VALID && OUT_READY at a rising edge.
- IN_READY = (state==IDLE) || (OUT_READY && OUT_LAST). It is combinational from OUT_READY; there is no combinational path from IN_VALID.
- On input transfer:
  - Load rBuffer and rCount = effective n.
  - Set rIdx = 0 if MSB_FIRST=0, else IN_BYTES-1.
  - Go to SEND.
- Byte mapping: DATA_OUT = rBuffer[8*rIdx+7 : 8*rIdx].
  - MSB_FIRST=0 sends bytes 0..n-1.
  - MSB_FIRST=1 sends bytes IN_BYTES-1 down to IN_BYTES-n.
- On output transfer with rCount>1: decrement rCount; increment rIdx (MSB_FIRST=0) or decrement it (MSB_FIRST=1).
- On output transfer with rCount==1 (OUT_LAST):
  - Simultaneous input transfer: load the new word and stay in SEND (back-to-back).
  - Otherwise: go to IDLE.
- OUT_VALID = (state==SEND). OUT_LAST = (rCount==1). IDLE_BUFFER = (state==IDLE).
- OUT_VALID stays high and DATA_OUT stays stable while OUT_READY is low. No byte is ever dropped or repeated.
- IN_BYTES=1: every word is a single byte with OUT_LAST=1, giving a registered pass-through at full rate.

## Timing
- Reset values (asserted asynchronously, released synchronously):
  - state=IDLE, rCount=0, rIdx=0, rBuffer=0.
  - DATA_OUT=0, OUT_VALID=0, OUT_LAST=0, IDLE_BUFFER=1, IN_READY=1.
- Latency: the word accepted at edge k has its first byte on DATA_OUT after edge k, visible in cycle k+1.
- Throughput: with OUT_READY held high, a word of n bytes occupies exactly n output cycles. The next word is accepted on the edge of the last byte, so there are zero idle cycles between words.
- Backpressure: OUT_READY low freezes all state. IN_READY stays low in SEND until the last byte is being accepted.
- Reset mid-word: the word is discarded. OUT_VALID drops immediately on RESET_N low and nothing of that word is emitted after release.
- IN_VALID while IN_READY=0 has no effect. The source must hold the word (standard valid/ready).

## Test plan
- IN_BYTES=4, MSB_FIRST=0, DATA_IN=32'hDDCCBBAA, IN_NBYTES=4, OUT_READY=1 -> AA,BB,CC,DD on four consecutive cycles starting one cycle after accept; OUT_LAST only with DD; IDLE_BUFFER returns to 1 after DD.
- Same setup with two words 32'hDDCCBBAA then 32'h44332211 offered back-to-back -> 8 consecutive bytes AA..DD,11..44 with no gap; IN_READY high only in the DD cycle.
- MSB_FIRST=1, DATA_IN=32'h11223344, IN_NBYTES=2 -> 11,22 with OUT_LAST on 22; IN_NBYTES=0 -> 11,22,33,44.
- OUT_READY toggled 1,0,0,1,0,1,1 during 32'hDDCCBBAA -> DATA_OUT holds each byte while stalled; exactly AA,BB,CC,DD delivered, none duplicated.
- Assert RESET_N low after BB is transferred -> OUT_VALID=0, IDLE_BUFFER=1, IN_READY=1 immediately; after release the next word starts at its first byte.
- IN_BYTES=1, random bytes with IN_VALID=OUT_READY=1 -> one byte per cycle, one-cycle latency, OUT_LAST constantly 1.

Source files
------------

// File: rtl/size_convert_stream.sv
`default_nettype none
// ============================================================================
//  Module   : size_convert_stream
//  Function : Word-to-byte serializer with valid/ready on both sides. Accepts
//             a full or partial IN_BYTES-wide word and emits its bytes in a
//             configurable order, flagging the final byte of each word.
//  Revision : 1.0  initial release
// ============================================================================
module size_convert_stream #(
  parameter  int IN_BYTES  = 4,
  parameter  int MSB_FIRST = 0,
  localparam int CW        = $clog2(IN_BYTES) + 1
) (
  input  logic                  PCLK,
  input  logic                  RESET_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [8*IN_BYTES-1:0] DATA_IN,
  input  logic [CW-1:0]         IN_NBYTES,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [7:0]            DATA_OUT,
  output logic                  OUT_LAST,
  output logic                  IDLE_BUFFER
);

  // Byte index width; a one-byte word still needs a one-bit index register.
  localparam int IW = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;

  localparam logic [CW-1:0] c_full      = CW'(IN_BYTES);
  localparam logic [CW-1:0] c_one       = CW'(1);
  localparam logic [IW-1:0] c_idx_start = (MSB_FIRST != 0) ? IW'(IN_BYTES - 1) : '0;

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_send = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_next_state;
  logic [8*IN_BYTES-1:0] r_buffer;
  logic [CW-1:0]         r_count;
  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         w_nbytes_eff;
  logic [IW-1:0]         w_idx_step;
  logic                  w_last;
  logic                  w_in_xfer;
  logic                  w_out_xfer;

  // The byte being presented is the last of its word when one byte remains.
  assign w_last     = (r_count == c_one);
  assign OUT_LAST   = w_last;
  assign w_in_xfer  = IN_VALID && IN_READY;
  assign w_out_xfer = OUT_VALID && OUT_READY;

  // Out-of-range byte counts (zero or larger than the word) mean a full word.
  always_comb begin
    w_nbytes_eff = IN_NBYTES;
    if ((IN_NBYTES == '0) || (IN_NBYTES > c_full)) begin
      w_nbytes_eff = c_full;
    end
  end

  // Walk upward through the word for LSB-first order, downward for MSB-first.
  always_comb begin
    if (MSB_FIRST != 0) begin
      w_idx_step = r_idx - IW'(1);
    end else begin
      w_idx_step = r_idx + IW'(1);
    end
  end

  // State register.
  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Leave SEND only when the last byte goes out with no new word arriving.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: begin
        if (IN_VALID) begin
          w_next_state = c_send;
        end
      end
      c_send: begin
        if (OUT_READY && w_last && !IN_VALID) begin
          w_next_state = c_idle;
        end
      end
      default: w_next_state = c_idle;
    endcase
  end

  // Handshake outputs; accepting in SEND only as the final byte drains keeps
  // words back-to-back without a bubble.
  always_comb begin
    OUT_VALID   = (r_state == c_send);
    IDLE_BUFFER = (r_state == c_idle);
    IN_READY    = (r_state == c_idle) || (OUT_READY && w_last);
  end

  // Word, remaining-count and index registers; a new word takes priority over
  // stepping because it can only arrive together with the last byte.
  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_buffer <= '0;
      r_count  <= '0;
      r_idx    <= '0;
    end else if (w_in_xfer) begin
      r_buffer <= DATA_IN;
      r_count  <= w_nbytes_eff;
      r_idx    <= c_idx_start;
    end else if (w_out_xfer) begin
      r_count  <= r_count - c_one;
      r_idx    <= w_idx_step;
    end
  end

  // Select the byte addressed by the current index.
  always_comb begin
    DATA_OUT = '0;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (r_idx == IW'(i)) begin
        DATA_OUT = r_buffer[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_size_convert_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_size_convert_stream
//  Function : Scoreboard bench for size_convert_stream. Three instances
//             (4-byte LSB-first, 4-byte MSB-first, 1-byte) are driven with
//             directed and random words; a per-instance monitor compares the
//             byte stream against a queue filled from a byte-order model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_size_convert_stream;

  localparam int NI = 3;

  logic        PCLK = 1'b0;
  logic        RESET_N;

  logic        in_valid [NI];
  logic [31:0] data_in  [NI];
  logic [2:0]  nbytes   [NI];
  logic        or_level [NI];
  logic        bp_en    [NI];

  wire         out_ready[NI];
  wire         in_ready [NI];
  wire         out_valid[NI];
  wire  [7:0]  data_out [NI];
  wire         out_last [NI];
  wire         idle_buf [NI];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          pending  [NI];

  int          pat [7] = '{1, 0, 0, 1, 0, 1, 1};

  // Free-running clock.
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input int g, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s (inst %0d): got 0x%0h, required 0x%0h at %0t", name, g, act, exp, $time);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int NB = (g == 2) ? 1 : 4;
    localparam int MS = (g == 1) ? 1 : 0;
    localparam int CW = $clog2(NB) + 1;

    logic [8:0] q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       rnd_or     = 1'b1;

    assign out_ready[g] = bp_en[g] ? rnd_or : or_level[g];

    size_convert_stream #(
      .IN_BYTES  (NB),
      .MSB_FIRST (MS)
    ) u_dut (
      .PCLK        (PCLK),
      .RESET_N     (RESET_N),
      .IN_VALID    (in_valid[g]),
      .IN_READY    (in_ready[g]),
      .DATA_IN     (data_in[g][8*NB-1:0]),
      .IN_NBYTES   (nbytes[g][CW-1:0]),
      .OUT_VALID   (out_valid[g]),
      .OUT_READY   (out_ready[g]),
      .DATA_OUT    (data_out[g]),
      .OUT_LAST    (out_last[g]),
      .IDLE_BUFFER (idle_buf[g])
    );

    // Random backpressure, changed just after each rising edge.
    always @(posedge PCLK) begin
      #1;
      rnd_or = ($urandom_range(0, 3) != 0);
    end

    // Monitor: mid-cycle compare against the scoreboard, then retire the
    // byte about to be consumed and enqueue any word about to be accepted.
    always @(negedge PCLK) begin : p_mon
      int nb;
      int neff;
      int idx;
      if (!RESET_N) begin
        chk("rst_out_valid",   g, longint'(out_valid[g]), 0);
        chk("rst_out_last",    g, longint'(out_last[g]),  0);
        chk("rst_data_out",    g, longint'(data_out[g]),  0);
        chk("rst_idle_buffer", g, longint'(idle_buf[g]),  1);
        chk("rst_in_ready",    g, longint'(in_ready[g]),  1);
        q.delete();
        prev_stall = 1'b0;
      end else begin
        chk("out_valid",   g, longint'(out_valid[g]), longint'(q.size() != 0));
        chk("idle_buffer", g, longint'(idle_buf[g]),  longint'(q.size() == 0));
        chk("in_ready",    g, longint'(in_ready[g]),
            longint'((q.size() == 0) || (out_ready[g] && q.size() == 1)));
        if (out_valid[g] && q.size() != 0) begin
          chk("data_out", g, longint'(data_out[g]), longint'(q[0][7:0]));
          chk("out_last", g, longint'(out_last[g]), longint'(q[0][8]));
        end
        if (prev_stall) chk("stall_hold", g, longint'(data_out[g]), longint'(prev_data));
        prev_stall = out_valid[g] && !out_ready[g];
        prev_data  = data_out[g];
        if (out_valid[g] && out_ready[g] && q.size() != 0) void'(q.pop_front());
        if (in_valid[g] && in_ready[g]) begin
          nb   = int'(nbytes[g]) & ((1 << CW) - 1);
          neff = (nb == 0 || nb > NB) ? NB : nb;
          for (int k = 0; k < neff; k++) begin
            idx = (MS != 0) ? (NB - 1 - k) : k;
            q.push_back({(k == neff - 1), data_in[g][8*idx +: 8]});
          end
        end
      end
      pending[g] = q.size();
    end
  end

  // Offer one word and hold it until accepted; returns just after the
  // accepting edge so the next word can follow without a gap.
  task automatic drive_word(input int g, input logic [31:0] w, input logic [2:0] n);
    int t;
    t           = 0;
    in_valid[g] = 1'b1;
    data_in[g]  = w;
    nbytes[g]   = n;
    @(negedge PCLK);
    while (!in_ready[g] && t < 200) begin
      @(negedge PCLK);
      t++;
    end
    if (!in_ready[g]) chk("accept_timeout", g, 0, 1);
    @(posedge PCLK);
    #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic rand_run(input int g, input int nw);
    for (int i = 0; i < nw; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap == 3) begin
        repeat ($urandom_range(1, 3)) @(posedge PCLK);
        #1;
      end
      drive_word(g, $urandom, 3'($urandom_range(0, 7)));
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Directed scenarios followed by concurrent random traffic.
  initial begin
    int t;
    RESET_N = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0;
      data_in[i]  = '0;
      nbytes[i]   = '0;
      or_level[i] = 1'b0;
      bp_en[i]    = 1'b0;
      pending[i]  = 0;
    end
    #2 RESET_N = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 RESET_N = 1'b1;

    // Single full word, LSB first.
    or_level[0] = 1'b1;
    drive_word(0, 32'hDDCCBBAA, 3'd4);
    idle_cycles(6);

    // Two words back-to-back.
    drive_word(0, 32'hDDCCBBAA, 3'd4);
    drive_word(0, 32'h44332211, 3'd4);
    idle_cycles(6);

    // MSB first, partial then zero (= full) byte count.
    or_level[1] = 1'b1;
    drive_word(1, 32'h11223344, 3'd2);
    drive_word(1, 32'h11223344, 3'd0);
    idle_cycles(6);

    // Stall pattern during one word.
    drive_word(0, 32'hDDCCBBAA, 3'd4);
    for (int i = 0; i < 7; i++) begin
      or_level[0] = pat[i][0];
      @(posedge PCLK);
      #1;
    end
    or_level[0] = 1'b1;
    idle_cycles(4);

    // Reset after the second byte has been transferred.
    drive_word(0, 32'hDDCCBBAA, 3'd4);
    idle_cycles(1);
    idle_cycles(1);
    RESET_N = 1'b0;
    #1;
    chk("async_rst_out_valid",   0, longint'(out_valid[0]), 0);
    chk("async_rst_idle_buffer", 0, longint'(idle_buf[0]),  1);
    chk("async_rst_in_ready",    0, longint'(in_ready[0]),  1);
    repeat (2) @(posedge PCLK);
    #1 RESET_N = 1'b1;
    drive_word(0, 32'h44332211, 3'd4);
    idle_cycles(6);

    // One-byte instance at full rate.
    or_level[2] = 1'b1;
    for (int i = 0; i < 20; i++) drive_word(2, $urandom, 3'd1);
    idle_cycles(3);

    // Random traffic with random backpressure on all instances.
    for (int i = 0; i < NI; i++) bp_en[i] = 1'b1;
    fork
      rand_run(0, 150);
      rand_run(1, 150);
      rand_run(2, 150);
    join
    for (int i = 0; i < NI; i++) begin
      bp_en[i]    = 1'b0;
      or_level[i] = 1'b1;
    end

    t = 0;
    while ((pending[0] != 0 || pending[1] != 0 || pending[2] != 0) && t < 1000) begin
      @(posedge PCLK);
      t++;
    end
    @(negedge PCLK);
    for (int i = 0; i < NI; i++) chk("drain", i, longint'(pending[i]), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
